tpu_tile_sequencer: RTL and testbench

- Parametrised successor to the fixed 8x8 TPU system controller.
- Sequences memory load, weight pre-load, compensation-weight pre-load, systolic compute and result drain for SIZE x SIZE arrays with CROWS compensation rows.
- Loops over multiple weight/activation tiles and adds a ready/valid output drain.
- Drives the strobes consumed by the weight memory, compensation memory, activation memory/buffer and accumulators.

---
 rtl/tpu_seq_pkg.sv | 20 ++
 rtl/tpu_tile_sequencer_if.sv | 51 +++++
 rtl/tpu_phase_counter.sv | 37 +++
 rtl/tpu_tile_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_tpu_tile_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_seq_pkg.sv
// Shared definitions for the TPU tile sequencer: FSM state encoding,
// default compute-phase length and performance counter width.
package tpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_MEM = 3'd1,
    ST_PRELOAD  = 3'd2,
    ST_CAL      = 3'd3,
    ST_OUT      = 3'd4
  } state_e;

  localparam int PERF_W = 32;

  // SIZE-1 skew + 2*SIZE-1 wavefront + 1 output cycle
  function automatic int cal_cycles_default(input int size);
    return 3 * size - 1;
  endfunction

endpackage

// File: rtl/tpu_tile_sequencer_if.sv
// Control/handshake bundle between the tile sequencer and its memories/drain.
// Perf counter signals exist only when TPU_SEQ_PERF_CNT_EN is defined.
interface tpu_tile_sequencer_if #(
  parameter int SIZE   = 8,
  parameter int TILE_W = 8
) ();
  localparam int COL_W = $clog2(SIZE);

  logic              start;
  logic [TILE_W-1:0] num_tiles;
  logic              abort;
  logic              load_mem_done;
  logic              out_ready;
  logic              load_req;
  logic              preload_weight;
  logic              preload_cweight;
  logic              cal;
  logic              out_valid;
  logic [COL_W-1:0]  out_col;
  logic [TILE_W-1:0] tile_idx;
  logic              busy;
  logic              done;

`ifdef TPU_SEQ_PERF_CNT_EN
  logic [tpu_seq_pkg::PERF_W-1:0] perf_cycles;
  logic [tpu_seq_pkg::PERF_W-1:0] perf_stall;

  modport master (
    output start, num_tiles, abort, load_mem_done, out_ready,
    input  load_req, preload_weight, preload_cweight, cal, out_valid,
    input  out_col, tile_idx, busy, done, perf_cycles, perf_stall
  );
  modport slave (
    input  start, num_tiles, abort, load_mem_done, out_ready,
    output load_req, preload_weight, preload_cweight, cal, out_valid,
    output out_col, tile_idx, busy, done, perf_cycles, perf_stall
  );
`else
  modport master (
    output start, num_tiles, abort, load_mem_done, out_ready,
    input  load_req, preload_weight, preload_cweight, cal, out_valid,
    input  out_col, tile_idx, busy, done
  );
  modport slave (
    input  start, num_tiles, abort, load_mem_done, out_ready,
    output load_req, preload_weight, preload_cweight, cal, out_valid,
    output out_col, tile_idx, busy, done
  );
`endif

endinterface

// File: rtl/tpu_phase_counter.sv
// Loadable up-counter with clear (highest priority) and a terminal-count
// compare against a caller-supplied last value.
module tpu_phase_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic [W-1:0] i_tc_val,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // count register: clear > load > increment > hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= {W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_tc_val);

endmodule

// File: rtl/tpu_tile_sequencer.sv
// Multi-tile TPU sequencer: load -> weight preload -> compute -> ready/valid drain.
// Define TPU_SEQ_PERF_CNT_EN to add busy-cycle and drain-stall counters.
module tpu_tile_sequencer
  import tpu_seq_pkg::*;
#(
  parameter int SIZE       = 8,
  parameter int CROWS      = 3,
  parameter int CAL_CYCLES = cal_cycles_default(SIZE),
  parameter int TILE_W     = 8,
  parameter int CNT_W      = $clog2(CAL_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  tpu_tile_sequencer_if.slave bus
);

  localparam int COL_W = $clog2(SIZE);
  localparam logic [CNT_W-1:0] L_PRE_LAST = CNT_W'(SIZE - 1);
  localparam logic [CNT_W-1:0] L_CAL_LAST = CNT_W'(CAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_CROWS    = CNT_W'(CROWS);
  localparam logic [COL_W-1:0] L_COL_LAST = COL_W'(SIZE - 1);

  state_e r_state;
  state_e w_state_next;

  logic [TILE_W-1:0] r_num_tiles;
  logic [TILE_W-1:0] r_tile_idx;
  logic r_load_req, r_preload_weight, r_preload_cweight, r_cal;
  logic r_out_valid, r_busy, r_done;

  logic [CNT_W-1:0] w_phase_cnt, w_phase_inc, w_phase_tc_val;
  logic             w_phase_tc, w_phase_clr, w_phase_en;
  logic [COL_W-1:0] w_col;
  logic             w_col_tc, w_col_clr;

  logic w_abort, w_start_ok, w_start_zero, w_hs, w_last_col, w_last_tile;

  assign w_abort      = bus.abort && (r_state != ST_IDLE);
  assign w_start_ok   = (r_state == ST_IDLE) && bus.start && (bus.num_tiles != {TILE_W{1'b0}});
  assign w_start_zero = (r_state == ST_IDLE) && bus.start && (bus.num_tiles == {TILE_W{1'b0}});
  assign w_hs         = (r_state == ST_OUT) && bus.out_ready;
  assign w_last_col   = w_hs && w_col_tc;
  assign w_last_tile  = ({1'b0, r_tile_idx} + {{TILE_W{1'b0}}, 1'b1}) >= {1'b0, r_num_tiles};

  // next-state decode; abort overrides every busy state
  always_comb begin
    w_state_next = r_state;
    if (w_abort) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) w_state_next = ST_LOAD_MEM;
          else            w_state_next = ST_IDLE;
        end
        ST_LOAD_MEM: begin
          if (bus.load_mem_done) w_state_next = ST_PRELOAD;
          else                   w_state_next = ST_LOAD_MEM;
        end
        ST_PRELOAD: begin
          if (w_phase_tc) w_state_next = ST_CAL;
          else            w_state_next = ST_PRELOAD;
        end
        ST_CAL: begin
          if (w_phase_tc) w_state_next = ST_OUT;
          else            w_state_next = ST_CAL;
        end
        ST_OUT: begin
          if (w_last_col) begin
            if (w_last_tile) w_state_next = ST_IDLE;
            else             w_state_next = ST_LOAD_MEM;
          end else begin
            w_state_next = ST_OUT;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // Moore strobes registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_load_req        <= 1'b0;
      r_preload_weight  <= 1'b0;
      r_preload_cweight <= 1'b0;
      r_cal             <= 1'b0;
      r_out_valid       <= 1'b0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
    end else begin
      r_load_req        <= (w_state_next == ST_LOAD_MEM) && (r_state != ST_LOAD_MEM);
      r_preload_weight  <= (w_state_next == ST_PRELOAD);
      r_preload_cweight <= (w_state_next == ST_PRELOAD) &&
                           ((r_state != ST_PRELOAD) || (w_phase_inc < L_CROWS));
      r_cal             <= (w_state_next == ST_CAL);
      r_out_valid       <= (w_state_next == ST_OUT);
      r_busy            <= (w_state_next != ST_IDLE);
      r_done            <= w_start_zero || (w_last_col && w_last_tile && !w_abort);
    end
  end

  // job bookkeeping: tile count latch and current tile
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_num_tiles <= {TILE_W{1'b0}};
      r_tile_idx  <= {TILE_W{1'b0}};
    end else if (w_abort) begin
      r_num_tiles <= {TILE_W{1'b0}};
      r_tile_idx  <= {TILE_W{1'b0}};
    end else if (w_start_ok) begin
      r_num_tiles <= bus.num_tiles;
      r_tile_idx  <= {TILE_W{1'b0}};
    end else if (w_last_col && !w_last_tile) begin
      r_num_tiles <= r_num_tiles;
      r_tile_idx  <= r_tile_idx + TILE_W'(1);
    end else begin
      r_num_tiles <= r_num_tiles;
      r_tile_idx  <= r_tile_idx;
    end
  end

  assign w_phase_clr    = (w_state_next != r_state);
  assign w_phase_en     = (r_state == ST_PRELOAD) || (r_state == ST_CAL);
  assign w_phase_tc_val = (r_state == ST_CAL) ? L_CAL_LAST : L_PRE_LAST;
  assign w_phase_inc    = w_phase_cnt + CNT_W'(1);

  tpu_phase_counter #(.W(CNT_W)) u_phase_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_phase_clr),
    .i_load     (1'b0),
    .i_load_val ({CNT_W{1'b0}}),
    .i_en       (w_phase_en),
    .i_tc_val   (w_phase_tc_val),
    .o_cnt      (w_phase_cnt),
    .o_tc       (w_phase_tc)
  );

  // column index restarts on every phase change so it never wraps
  assign w_col_clr = (r_state != ST_OUT) || (w_state_next != r_state);

  tpu_phase_counter #(.W(COL_W)) u_col_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_col_clr),
    .i_load     (1'b0),
    .i_load_val ({COL_W{1'b0}}),
    .i_en       (w_hs),
    .i_tc_val   (L_COL_LAST),
    .o_cnt      (w_col),
    .o_tc       (w_col_tc)
  );

`ifdef TPU_SEQ_PERF_CNT_EN
  logic [PERF_W-1:0] r_perf_cycles;
  logic [PERF_W-1:0] r_perf_stall;

  // saturating busy-cycle and drain-stall counters, cleared by a start in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_cycles <= {PERF_W{1'b0}};
      r_perf_stall  <= {PERF_W{1'b0}};
    end else if ((r_state == ST_IDLE) && bus.start) begin
      r_perf_cycles <= {PERF_W{1'b0}};
      r_perf_stall  <= {PERF_W{1'b0}};
    end else begin
      if (r_busy && !(&r_perf_cycles)) r_perf_cycles <= r_perf_cycles + PERF_W'(1);
      else                             r_perf_cycles <= r_perf_cycles;
      if ((r_state == ST_OUT) && !bus.out_ready && !(&r_perf_stall))
        r_perf_stall <= r_perf_stall + PERF_W'(1);
      else
        r_perf_stall <= r_perf_stall;
    end
  end

  assign bus.perf_cycles = r_perf_cycles;
  assign bus.perf_stall  = r_perf_stall;
`endif

  assign bus.load_req        = r_load_req;
  assign bus.preload_weight  = r_preload_weight;
  assign bus.preload_cweight = r_preload_cweight;
  assign bus.cal             = r_cal;
  assign bus.out_valid       = r_out_valid;
  assign bus.out_col         = w_col;
  assign bus.tile_idx        = r_tile_idx;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Self-checking bench: phase-level reference model compared every cycle,
// plus directed jobs with hand-counted strobe totals.
module tb_tpu_tile_sequencer;

  localparam int SIZE   = 8;
  localparam int CROWS  = 3;
  localparam int CALC   = 23;
  localparam int TILE_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tpu_tile_sequencer_if #(.SIZE(SIZE), .TILE_W(TILE_W)) bus ();

  tpu_tile_sequencer #(.SIZE(SIZE), .CROWS(CROWS), .TILE_W(TILE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference model: phase 0 idle, 1 load, 2 preload, 3 compute, 4 drain
  int m_phase, m_elapsed, m_col, m_tile, m_ntiles;
  int m_cycles, m_stall;
  bit m_load_req, m_done;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_phase = 0; m_elapsed = 0; m_col = 0; m_tile = 0; m_ntiles = 0;
      m_cycles = 0; m_stall = 0; m_load_req = 0; m_done = 0;
    end else begin
      m_load_req = 0;
      m_done = 0;
      if (m_phase == 0 && bus.start) begin
        m_cycles = 0;
        m_stall = 0;
      end else begin
        if (m_phase != 0) m_cycles++;
        if (m_phase == 4 && !bus.out_ready) m_stall++;
      end
      if (m_phase != 0 && bus.abort) begin
        m_phase = 0; m_elapsed = 0; m_col = 0; m_tile = 0;
      end else begin
        case (m_phase)
          0: if (bus.start) begin
               if (bus.num_tiles == 0) m_done = 1;
               else begin
                 m_ntiles = bus.num_tiles; m_tile = 0; m_phase = 1; m_load_req = 1;
               end
             end
          1: if (bus.load_mem_done) begin m_phase = 2; m_elapsed = 0; end
          2: if (m_elapsed == SIZE - 1) begin m_phase = 3; m_elapsed = 0; end
             else m_elapsed++;
          3: if (m_elapsed == CALC - 1) begin m_phase = 4; m_col = 0; end
             else m_elapsed++;
          4: if (bus.out_ready) begin
               if (m_col == SIZE - 1) begin
                 m_col = 0;
                 if (m_tile + 1 < m_ntiles) begin m_tile++; m_phase = 1; m_load_req = 1; end
                 else begin m_phase = 0; m_done = 1; end
               end else m_col++;
             end
          default: m_phase = 0;
        endcase
      end
    end
  end

  // observed strobe statistics for hand-computed expectations
  int st_lr, st_pw, st_pcw, st_cal, st_hs, st_col_ok, st_done, st_busy, st_stall;
  int lr_tiles[0:7];

  task automatic clr_stats();
    st_lr = 0; st_pw = 0; st_pcw = 0; st_cal = 0; st_hs = 0;
    st_col_ok = 0; st_done = 0; st_busy = 0; st_stall = 0;
  endtask

  // per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    #1;
    check("busy",            bus.busy,            32'(m_phase != 0));
    check("load_req",        bus.load_req,        32'(m_load_req));
    check("preload_weight",  bus.preload_weight,  32'(m_phase == 2));
    check("preload_cweight", bus.preload_cweight, 32'(m_phase == 2 && m_elapsed < CROWS));
    check("cal",             bus.cal,             32'(m_phase == 3));
    check("out_valid",       bus.out_valid,       32'(m_phase == 4));
    check("out_col",         bus.out_col,         32'(m_col));
    check("tile_idx",        bus.tile_idx,        32'(m_tile));
    check("done",            bus.done,            32'(m_done));
`ifdef TPU_SEQ_PERF_CNT_EN
    check("perf_cycles",     bus.perf_cycles,     32'(m_cycles));
    check("perf_stall",      bus.perf_stall,      32'(m_stall));
`endif
    if (bus.load_req) begin
      if (st_lr < 8) lr_tiles[st_lr] = int'(bus.tile_idx);
      st_lr++;
    end
    if (bus.preload_weight)  st_pw++;
    if (bus.preload_cweight) st_pcw++;
    if (bus.cal)             st_cal++;
    if (bus.done)            st_done++;
    if (bus.busy)            st_busy++;
    if (bus.out_valid && !bus.out_ready) st_stall++;
    if (bus.out_valid && bus.out_ready) begin
      if (int'(bus.out_col) == st_hs % SIZE) st_col_ok++;
      st_hs++;
    end
  end

  // memory-load responder: load_mem_done follows load_req after ld_delay cycles
  int ld_delay = 0;
  int ld_cnt = -1;
  initial forever begin
    @(negedge clk);
    bus.load_mem_done = 1'b0;
    if (!rst) ld_cnt = -1;
    else begin
      if (bus.load_req) ld_cnt = ld_delay;
      if (ld_cnt == 0) begin bus.load_mem_done = 1'b1; ld_cnt = -1; end
      else if (ld_cnt > 0) ld_cnt--;
    end
  end

  // drain-side ready: constant 1 or the 1,0,0,1 pattern
  int rdy_mode = 0;
  int rdy_ph = 0;
  initial forever begin
    @(negedge clk);
    if (rdy_mode == 0) bus.out_ready = 1'b1;
    else begin
      bus.out_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
      rdy_ph++;
    end
  end

  task automatic start_job(input int n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_tiles = TILE_W'(n);
    @(negedge clk);
    bus.start = 1'b0;
    bus.num_tiles = 8'd5;
  endtask

  task automatic wait_done(input int maxc, input string nm);
    int k;
    k = 0;
    while (bus.done !== 1'b1 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= maxc) begin
      n_errors++;
      $display("FAIL %s_timeout: no done within %0d cycles", nm, maxc);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.num_tiles = 8'd0;
    bus.abort = 1'b0;
    clr_stats();
    repeat (3) @(negedge clk);
    #2;
    check("rst_busy", bus.busy, 32'd0);
    check("rst_tile_idx", bus.tile_idx, 32'd0);
    check("rst_out_col", bus.out_col, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // A: single tile, ready always high
    clr_stats();
    start_job(1);
    wait_done(200, "A");
    check("A_load_req", st_lr, 32'd1);
    check("A_preload_w", st_pw, 32'd8);
    check("A_preload_cw", st_pcw, 32'd3);
    check("A_cal", st_cal, 32'd23);
    check("A_handshakes", st_hs, 32'd8);
    check("A_col_order", st_col_ok, 32'd8);
    check("A_done", st_done, 32'd1);
    check("A_busy_cycles", st_busy, 32'd40);

    // B: three tiles, memory answers 4 cycles after each request
    ld_delay = 4;
    clr_stats();
    start_job(3);
    wait_done(600, "B");
    check("B_load_req", st_lr, 32'd3);
    check("B_tile0", lr_tiles[0], 32'd0);
    check("B_tile1", lr_tiles[1], 32'd1);
    check("B_tile2", lr_tiles[2], 32'd2);
    check("B_done", st_done, 32'd1);
    check("B_handshakes", st_hs, 32'd24);
    check("B_busy_cycles", st_busy, 32'd132);
    check("B_final_tile", bus.tile_idx, 32'd2);
    ld_delay = 0;

    // C: drain with out_ready toggling 1,0,0,1
    clr_stats();
    rdy_ph = 0;
    rdy_mode = 1;
    start_job(1);
    wait_done(400, "C");
    check("C_handshakes", st_hs, 32'd8);
    check("C_col_order", st_col_ok, 32'd8);
    check("C_stalls_seen", 32'(st_stall > 0), 32'd1);
    check("C_busy_cycles", st_busy, 32'(40 + st_stall));
`ifdef TPU_SEQ_PERF_CNT_EN
    check("C_perf_stall", bus.perf_stall, 32'(st_stall));
`endif
    rdy_mode = 0;

    // D: zero-tile start
    clr_stats();
    start_job(0);
    wait_done(5, "D");
    check("D_done", st_done, 32'd1);
    check("D_busy_cycles", st_busy, 32'd0);

    // E: abort at compute cycle 10 of tile 1 of 2, then a clean job
    clr_stats();
    start_job(2);
    begin
      int k;
      k = 0;
      while (!(bus.cal && bus.tile_idx == 8'd1) && k < 300) begin
        @(negedge clk);
        k++;
      end
      n_checks++;
      if (k >= 300) begin
        n_errors++;
        $display("FAIL E_reach_cal: tile 1 compute never seen");
      end
    end
    repeat (10) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    #1;
    check("E_busy_after_abort", bus.busy, 32'd0);
    check("E_cal_after_abort", bus.cal, 32'd0);
    repeat (5) @(negedge clk);
    check("E_no_done", st_done, 32'd0);
    check("E_load_req", st_lr, 32'd2);
    clr_stats();
    start_job(1);
    wait_done(200, "E2");
    check("E2_handshakes", st_hs, 32'd8);
    check("E2_done", st_done, 32'd1);
    check("E2_cal", st_cal, 32'd23);

    // F: reset in the middle of preload
    clr_stats();
    start_job(1);
    begin
      int k;
      k = 0;
      while (!bus.preload_weight && k < 50) begin
        @(negedge clk);
        k++;
      end
    end
    repeat (2) @(negedge clk);
    check("F_pre_reset_preload", bus.preload_weight, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("F_rst_busy", bus.busy, 32'd0);
    check("F_rst_preload_w", bus.preload_weight, 32'd0);
    check("F_rst_preload_cw", bus.preload_cweight, 32'd0);
    check("F_rst_cal", bus.cal, 32'd0);
    check("F_rst_out_valid", bus.out_valid, 32'd0);
    check("F_rst_load_req", bus.load_req, 32'd0);
    check("F_rst_done", bus.done, 32'd0);
    bus.start = 1'b1;
    bus.num_tiles = 8'd1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("F_idle_after_release", bus.busy, 32'd0);
    clr_stats();
    start_job(1);
    wait_done(200, "F2");
    check("F2_done", st_done, 32'd1);
    check("F2_handshakes", st_hs, 32'd8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
